// File: rtl/dnnweaver_buf_pkg.sv
// Shared sizing helpers and constants for the input/output buffer pair.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dnnweaver_buf_pkg;

  // Read path depth: one cycle for the RAM array read, one for its output register.
  localparam int RD_LATENCY = 2;

  function automatic int calc_group_size(input int mem_w, input int data_w);
    return mem_w / data_w;
  endfunction

  function automatic int calc_group_id_w(input int group_size);
    return (group_size == 1) ? 0 : $clog2(group_size);
  endfunction

  function automatic int calc_buf_id_w(input int array_n, input int group_size);
    return $clog2(array_n) - calc_group_id_w(group_size);
  endfunction

  // Address split for the default build (4 lanes, 64-bit memory word).
  localparam int DEF_BUF_ADDR_WIDTH = 10;
  localparam int DEF_BUF_ID_W       = calc_buf_id_w(4, calc_group_size(64, 32));

  typedef struct packed {
    logic [DEF_BUF_ADDR_WIDTH-1:0] bank_addr;
    logic [DEF_BUF_ID_W-1:0]       buf_id;
  } mem_addr_t;

endpackage

// File: rtl/obuf_lane.sv
// One output-buffer bank: skews the array write by LANE_ID cycles and decodes the group read.
// Latency: write lands LANE_ID cycles after lane-0 strobe; read data 2 cycles after request.
// Backpressure: none. OBUF_COLLISION_DETECT_EN adds the per-bank collision output.
module obuf_lane
  import dnnweaver_buf_pkg::*;
#(
  parameter int LANE_ID        = 0,
  parameter int DATA_WIDTH     = 32,
  parameter int BUF_ADDR_WIDTH = 10,
  parameter int GROUP_SIZE     = 2,
  parameter int BUF_ID_W       = 1,
  parameter int ID_W           = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      array_req,
  input  logic [BUF_ADDR_WIDTH-1:0] array_addr,
  input  logic [DATA_WIDTH-1:0]     array_data,
  output logic                      lane_busy,
  input  logic                      rd_req,
  input  logic [BUF_ADDR_WIDTH-1:0] rd_bank,
  input  logic [ID_W-1:0]           rd_id,
  output logic [DATA_WIDTH-1:0]     rd_data
`ifdef OBUF_COLLISION_DETECT_EN
  ,
  output logic                      coll
`endif
);

  localparam int GROUP_IDX = LANE_ID / GROUP_SIZE;

  logic [BUF_ADDR_WIDTH:0]   skew [LANE_ID+1];
  logic                      wr_req;
  logic [BUF_ADDR_WIDTH-1:0] wr_addr;
  logic                      rd_en;

  assign skew[0] = {array_req, array_addr};

  for (genvar i = 0; i < LANE_ID; i++) begin : g_skew
    register_sync #(.WIDTH(BUF_ADDR_WIDTH + 1)) u_skew (
      .clk   (clk),
      .reset (reset),
      .d     (skew[i]),
      .q     (skew[i+1])
    );
  end

  assign {wr_req, wr_addr} = skew[LANE_ID];

  // lane 0 never contributes: busy only covers the delayed lanes
  assign lane_busy = (LANE_ID != 0) && wr_req;

  // with no group bits every bank answers every read
  assign rd_en = rd_req && ((BUF_ID_W == 0) || (rd_id == ID_W'(GROUP_IDX)));

`ifdef OBUF_COLLISION_DETECT_EN
  assign coll = wr_req && rd_en && (wr_addr == rd_bank);
`endif

  ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (BUF_ADDR_WIDTH),
    .OUTPUT_REG (1)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_req),
    .wr_addr (wr_addr),
    .wr_data (array_data),
    .rd_en   (rd_en),
    .rd_addr (rd_bank),
    .rd_data (rd_data)
  );

endmodule

// File: rtl/ram.sv
// Simple dual-port RAM, read-first, with optional output register.
// Latency: 1 cycle (OUTPUT_REG=0) or 2 cycles (OUTPUT_REG=1).
// Backpressure: none; read data registers hold between reads.
module ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int OUTPUT_REG = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [1<<ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  rd_en_q;

  // array write; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // array read; non-blocking update gives old data on a same-address write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q    <= '0;
      rd_en_q <= 1'b0;
    end else begin
      rd_en_q <= rd_en;
      if (rd_en) rd_q <= mem[rd_addr];
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] out_q;
      // output register only moves when a read is in flight, so data holds otherwise
      always_ff @(posedge clk or posedge reset) begin
        if (reset)        out_q <= '0;
        else if (rd_en_q) out_q <= rd_q;
      end
      assign rd_data = out_q;
    end else begin : g_noreg
      assign rd_data = rd_q;
    end
  endgenerate

endmodule

// File: rtl/register_sync.sv
// Single pipeline register with asynchronous clear, used to build skew chains.
// Latency: 1 cycle.
// Backpressure: none; captures every cycle.
module register_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // plain delay stage, cleared on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/obuf.sv
// Output buffer: de-skewed array writes into ARRAY_N banks, grouped memory-word reads for DMA.
// Latency: read data and mem_read_valid 2 cycles after mem_read_req; one read per cycle.
// Backpressure: none on either side. OBUF_COLLISION_DETECT_EN builds the sticky collision flag.
module obuf
  import dnnweaver_buf_pkg::*;
#(
  parameter int MEM_DATA_WIDTH = 64,
  parameter int ARRAY_N        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int BUF_ADDR_WIDTH = 10,
  parameter int GROUP_SIZE     = calc_group_size(MEM_DATA_WIDTH, DATA_WIDTH),
  parameter int GROUP_ID_W     = calc_group_id_w(GROUP_SIZE),
  parameter int BUF_ID_W       = calc_buf_id_w(ARRAY_N, GROUP_SIZE),
  parameter int MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + BUF_ID_W,
  parameter int BUF_DATA_WIDTH = ARRAY_N * DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      buf_write_req,
  input  logic [BUF_ADDR_WIDTH-1:0] buf_write_addr,
  input  logic [BUF_DATA_WIDTH-1:0] buf_write_data,
  output logic                      buf_write_busy,
  input  logic                      mem_read_req,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_read_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_read_data,
  output logic                      mem_read_valid,
  output logic                      collision_err
);

  localparam int ID_W       = (BUF_ID_W > 0) ? BUF_ID_W : 1;
  localparam int NUM_GROUPS = ARRAY_N / GROUP_SIZE;

  logic [BUF_ADDR_WIDTH-1:0]                 rd_bank;
  logic [ID_W-1:0]                           rd_id;
  logic                                      rd_oor;
  logic [ARRAY_N-1:0]                        lane_busy;
  logic [ARRAY_N-1:0][DATA_WIDTH-1:0]        lane_rd;
  logic [RD_LATENCY-1:0]                     vld_pipe;
  logic [RD_LATENCY-1:0][ID_W-1:0]           id_pipe;
  logic [RD_LATENCY-1:0]                     oor_pipe;

  assign rd_bank = mem_read_addr[MEM_ADDR_WIDTH-1 -: BUF_ADDR_WIDTH];

  generate
    if (BUF_ID_W > 0) begin : g_id
      assign rd_id = mem_read_addr[ID_W-1:0];
    end else begin : g_noid
      assign rd_id = '0;
    end
  endgenerate

  // group ids past the last populated group read back as zero
  assign rd_oor = ({1'b0, rd_id} >= (ID_W+1)'(NUM_GROUPS));

`ifdef OBUF_COLLISION_DETECT_EN
  logic [ARRAY_N-1:0] lane_coll;
`endif

  for (genvar n = 0; n < ARRAY_N; n++) begin : g_lane
    obuf_lane #(
      .LANE_ID        (n),
      .DATA_WIDTH     (DATA_WIDTH),
      .BUF_ADDR_WIDTH (BUF_ADDR_WIDTH),
      .GROUP_SIZE     (GROUP_SIZE),
      .BUF_ID_W       (BUF_ID_W),
      .ID_W           (ID_W)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .array_req  (buf_write_req),
      .array_addr (buf_write_addr),
      .array_data (buf_write_data[n*DATA_WIDTH +: DATA_WIDTH]),
      .lane_busy  (lane_busy[n]),
      .rd_req     (mem_read_req),
      .rd_bank    (rd_bank),
      .rd_id      (rd_id),
      .rd_data    (lane_rd[n])
`ifdef OBUF_COLLISION_DETECT_EN
      ,
      .coll       (lane_coll[n])
`endif
    );
  end

  assign buf_write_busy = |lane_busy;

  // track the read alongside the RAM; id/oor stages only advance with a live read so the mux holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
      oor_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RD_LATENCY-2:0], mem_read_req};
      if (mem_read_req) begin
        id_pipe[0]  <= rd_id;
        oor_pipe[0] <= rd_oor;
      end
      for (int k = 1; k < RD_LATENCY; k++) begin
        if (vld_pipe[k-1]) begin
          id_pipe[k]  <= id_pipe[k-1];
          oor_pipe[k] <= oor_pipe[k-1];
        end
      end
    end
  end

  assign mem_read_valid = vld_pipe[RD_LATENCY-1];

  // pick the lane group that was addressed two cycles ago
  always_comb begin
    mem_read_data = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (!oor_pipe[RD_LATENCY-1] && (id_pipe[RD_LATENCY-1] == ID_W'(g)))
        mem_read_data = lane_rd[g*GROUP_SIZE +: GROUP_SIZE];
    end
  end

`ifdef OBUF_COLLISION_DETECT_EN
  logic coll_q;

  // sticky: same-cycle bank/address hit, or a read landing while skewed writes are in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      coll_q <= 1'b0;
    else if ((|lane_coll) || (mem_read_req && buf_write_busy))
      coll_q <= 1'b1;
  end

  assign collision_err = coll_q;
`else
  assign collision_err = 1'b0;
`endif

endmodule

// File: tb/tb_obuf.sv
// Scoreboarded bench for obuf: default 4-lane build plus a 6-lane build for out-of-range groups.
// Latency: checks 2-cycle read latency per transaction.
// Backpressure: none exercised (design has none).
`timescale 1ns/1ps
module tb_obuf;
  import dnnweaver_buf_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int MW  = 64;
  localparam int MAW = 11;
`ifdef OBUF_COLLISION_DETECT_EN
  localparam logic COLL_ON = 1'b1;
`else
  localparam logic COLL_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          buf_write_req;
  logic [AW-1:0] buf_write_addr;
  logic [N*DW-1:0] buf_write_data;
  logic          buf_write_busy;
  logic          mem_read_req;
  logic [MAW-1:0] mem_read_addr;
  logic [MW-1:0] mem_read_data;
  logic          mem_read_valid;
  logic          collision_err;

  logic          b_write_req;
  logic [AW-1:0] b_write_addr;
  logic [6*DW-1:0] b_write_data;
  logic          b_write_busy;
  logic          b_read_req;
  logic [11:0]   b_read_addr;
  logic [MW-1:0] b_read_data;
  logic          b_read_valid;
  logic          b_collision_err;

  obuf dut (
    .clk            (clk),
    .reset          (reset),
    .buf_write_req  (buf_write_req),
    .buf_write_addr (buf_write_addr),
    .buf_write_data (buf_write_data),
    .buf_write_busy (buf_write_busy),
    .mem_read_req   (mem_read_req),
    .mem_read_addr  (mem_read_addr),
    .mem_read_data  (mem_read_data),
    .mem_read_valid (mem_read_valid),
    .collision_err  (collision_err)
  );

  obuf #(.MEM_DATA_WIDTH(64), .ARRAY_N(6), .DATA_WIDTH(32), .BUF_ADDR_WIDTH(10)) dut6 (
    .clk            (clk),
    .reset          (reset),
    .buf_write_req  (b_write_req),
    .buf_write_addr (b_write_addr),
    .buf_write_data (b_write_data),
    .buf_write_busy (b_write_busy),
    .mem_read_req   (b_read_req),
    .mem_read_addr  (b_read_addr),
    .mem_read_data  (b_read_data),
    .mem_read_valid (b_read_valid),
    .collision_err  (b_collision_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vcount = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] dat;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  logic             s_vld  [N];
  logic [AW-1:0]    s_addr [N];
  logic [N*DW-1:0]  s_row  [N];
  logic [DW-1:0]    model  [N][1024];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [MAW-1:0] maddr(input int bank, input int id);
    mem_addr_t a;
    a.bank_addr = AW'(bank);
    a.buf_id    = 1'(id);
    return a;
  endfunction

  function automatic logic [DW-1:0] bval(input int a, input int n);
    return 32'hB000_0000 | (32'(a) << 8) | 32'(n);
  endfunction

  // monitor for the 4-lane build: pops one expectation per valid, checks data, latency and hold
  logic [63:0] last1 = '0;
  always @(negedge clk) begin
    if (reset) begin
      last1 = '0;
    end else if (mem_read_valid) begin
      vcount++;
      if (q1.size() == 0) begin
        check("unexpected_valid", 64'(mem_read_valid), 64'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check({e.name, "_data"}, mem_read_data, e.dat);
        check({e.name, "_lat"}, 64'(cyc - e.cyc), 64'(RD_LATENCY));
      end
      last1 = mem_read_data;
    end else begin
      check("hold_data", mem_read_data, last1);
    end
  end

  // monitor for the 6-lane build
  always @(negedge clk) begin
    if (!reset && b_read_valid) begin
      if (q2.size() == 0) begin
        check("b_unexpected_valid", 64'(b_read_valid), 64'd0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        check({e.name, "_data"}, b_read_data, e.dat);
        check({e.name, "_lat"}, 64'(cyc - e.cyc), 64'(RD_LATENCY));
      end
    end
  end

  // one clock of stimulus; the bench skews the row data itself the way the array would
  task automatic step(input logic wr, input int waddr, input logic [N*DW-1:0] row,
                      input logic rd, input logic [MAW-1:0] raddr,
                      input logic use_exp, input logic [63:0] exp_dat, input string name);
    exp_t e;
    mem_addr_t a;
    logic busy_exp;
    for (int n = N-1; n > 0; n--) begin
      s_vld[n]  = s_vld[n-1];
      s_addr[n] = s_addr[n-1];
      s_row[n]  = s_row[n-1];
    end
    s_vld[0]  = wr;
    s_addr[0] = AW'(waddr);
    s_row[0]  = row;
    buf_write_req  = wr;
    buf_write_addr = AW'(waddr);
    for (int n = 0; n < N; n++)
      buf_write_data[n*DW +: DW] = s_vld[n] ? s_row[n][n*DW +: DW] : (32'hDEAD_0000 | 32'(n));
    mem_read_req  = rd;
    mem_read_addr = raddr;
    if (rd) begin
      a = raddr;
      e.dat  = use_exp ? exp_dat
                       : {model[2*a.buf_id+1][a.bank_addr], model[2*a.buf_id][a.bank_addr]};
      e.cyc  = cyc;
      e.name = name;
      q1.push_back(e);
    end
    for (int n = 0; n < N; n++)
      if (s_vld[n]) model[n][s_addr[n]] = s_row[n][n*DW +: DW];
    @(posedge clk);
    #1;
    busy_exp = 1'b0;
    for (int n = 0; n < N-1; n++) busy_exp |= s_vld[n];
    check("busy", 64'(buf_write_busy), 64'(busy_exp));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 0, '0, 1'b0, '0, 1'b0, '0, "");
  endtask

  task automatic wr_row(input int addr, input logic [N*DW-1:0] row);
    step(1'b1, addr, row, 1'b0, '0, 1'b0, '0, "");
  endtask

  task automatic rd_model(input logic [MAW-1:0] raddr, input string name);
    step(1'b0, 0, '0, 1'b1, raddr, 1'b0, '0, name);
  endtask

  task automatic rd_exp(input logic [MAW-1:0] raddr, input logic [63:0] exp_dat, input string name);
    step(1'b0, 0, '0, 1'b1, raddr, 1'b1, exp_dat, name);
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    q1.delete();
    for (int n = 0; n < N; n++) s_vld[n] = 1'b0;
    buf_write_req = 1'b0;
    mem_read_req  = 1'b0;
    #1;
    check({name, "_busy"},  64'(buf_write_busy), 64'd0);
    check({name, "_valid"}, 64'(mem_read_valid), 64'd0);
    check({name, "_coll"},  64'(collision_err), 64'd0);
    check({name, "_data"},  mem_read_data, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic b_read(input logic [11:0] raddr, input logic [63:0] exp_dat, input string name);
    exp_t e;
    b_read_req  = 1'b1;
    b_read_addr = raddr;
    e.dat  = exp_dat;
    e.cyc  = cyc;
    e.name = name;
    q2.push_back(e);
    @(posedge clk);
    #1;
    b_read_req = 1'b0;
  endtask

  initial begin
    int v0;
    buf_write_req  = 1'b0;
    buf_write_addr = '0;
    buf_write_data = '0;
    mem_read_req   = 1'b0;
    mem_read_addr  = '0;
    b_write_req    = 1'b0;
    b_write_addr   = '0;
    b_write_data   = '0;
    b_read_req     = 1'b0;
    b_read_addr    = '0;
    for (int n = 0; n < N; n++) begin
      s_vld[n] = 1'b0; s_addr[n] = '0; s_row[n] = '0;
    end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  64'(buf_write_busy), 64'd0);
    check("rst_valid", 64'(mem_read_valid), 64'd0);
    check("rst_data",  mem_read_data, 64'd0);
    check("rst_coll",  64'(collision_err), 64'd0);
    check("rst_b_valid", 64'(b_read_valid), 64'd0);
    reset = 1'b0;
    idle(1);

    // skewed fill of address 5
    wr_row(5, {32'h44, 32'h33, 32'h22, 32'h11});
    idle(3);
    rd_exp(maddr(5, 0), 64'h00000022_00000011, "fill_g0");
    rd_exp(maddr(5, 1), 64'h00000044_00000033, "fill_g1");
    idle(3);

    // known contents at address 9 for the reset test
    wr_row(9, {32'h09000003, 32'h09000002, 32'h09000001, 32'h09000000});
    idle(3);

    // burst: 8 writes then 16 back-to-back reads covering banks 0..7, both groups
    for (int a = 0; a < 8; a++)
      wr_row(a, {bval(a, 3), bval(a, 2), bval(a, 1), bval(a, 0)});
    v0 = vcount;
    for (int i = 0; i < 16; i++) rd_model(MAW'(i), "burst");
    idle(3);
    check("burst_valid_cycles", 64'(vcount - v0), 64'd16);

    // read-first: lane 0 write and group-0 read of address 3 in one cycle
    step(1'b1, 3, {32'hD, 32'hC, 32'hB, 32'hA}, 1'b1, maddr(3, 0), 1'b1,
         {bval(3, 1), bval(3, 0)}, "rf_old");
    idle(3);
    check("rf_coll", 64'(collision_err), 64'(COLL_ON));
    rd_exp(maddr(3, 0), 64'h0000000B_0000000A, "rf_new");
    idle(3);

    // reset one cycle after a write to address 9, with a read in flight
    step(1'b1, 9, {32'hBEEF0003, 32'hBEEF0002, 32'hBEEF0001, 32'hBEEF0000}, 1'b1,
         maddr(5, 1), 1'b0, '0, "rst_pending");
    do_reset("midrst");
    idle(1);
    rd_exp(maddr(9, 0), 64'h09000001_BEEF0000, "midrst_g0");
    rd_exp(maddr(9, 1), 64'h09000003_09000002, "midrst_g1");
    idle(3);

    // collision: group-1 read of address 2 in the cycle lane 2 writes address 2
    check("coll_before", 64'(collision_err), 64'd0);
    wr_row(2, {32'h2D, 32'h2C, 32'h2B, 32'h2A});
    idle(1);
    rd_model(maddr(2, 1), "coll_rd");
    check("coll_set", 64'(collision_err), 64'(COLL_ON));
    idle(4);
    check("coll_sticky", 64'(collision_err), 64'(COLL_ON));
    do_reset("coll_rst");
    idle(1);

    // 6-lane build: one skewed row at address 1, then in-range and out-of-range groups
    for (int k = 0; k < 6; k++) begin
      b_write_req  = (k == 0);
      b_write_addr = 10'd1;
      for (int j = 0; j < 6; j++)
        b_write_data[j*DW +: DW] = (j == k) ? (32'h60 + 32'(j)) : 32'hDEAD_0000;
      @(posedge clk);
      #1;
    end
    b_write_req = 1'b0;
    @(posedge clk);
    #1;
    b_read({10'd1, 2'd0}, 64'h00000061_00000060, "b_g0");
    b_read({10'd1, 2'd2}, 64'h00000065_00000064, "b_g2");
    b_read({10'd1, 2'd3}, 64'h00000000_00000000, "b_oor");
    repeat (4) @(posedge clk);
    #1;
    check("b_busy", 64'(b_write_busy), 64'd0);
    check("b_coll", 64'(b_collision_err), 64'd0);

    idle(3);
    check("q1_drained", 64'(q1.size()), 64'd0);
    check("q2_drained", 64'(q2.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
